// File: rtl/fetch_sequencer_if.sv
// Byte memory port, redirect and decode handshake between fetch_sequencer and its neighbours.
interface fetch_sequencer_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_rdata;

   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   logic              instr_valid;
   logic              instr_ready;
   logic [1:0]        instr_type;
   logic [7:0]        instr_opcode;
   logic [7:0]        instr_ext;
   logic [7:0]        instr_operand;
   logic [7:0]        instr_imm;
   logic [2:0]        instr_len;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      input  redirect_valid, redirect_pc,
      output instr_valid, instr_type, instr_opcode, instr_ext,
      output instr_operand, instr_imm, instr_len, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      output redirect_valid, redirect_pc,
      input  instr_valid, instr_type, instr_opcode, instr_ext,
      input  instr_operand, instr_imm, instr_len, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Byte-serial variable-length instruction fetch for the smolproc front end.
// Classifies the opcode, gathers 2..4 bytes, then holds the instruction for decode.
module fetch_sequencer #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic               clk,
   input logic               rst_n,
   fetch_sequencer_if.master bus
);
   // Type encoding: bit 1 = extension byte present, bit 0 = immediate byte present
   localparam logic [1:0] T_NORMAL     = 2'd0;
   localparam logic [1:0] T_NORMAL_IMM = 2'd1;
   localparam logic [1:0] T_EXT        = 2'd2;
   localparam logic [1:0] T_EXT_IMM    = 2'd3;

   typedef enum logic [2:0] {
      F_OP   = 3'd0,
      F_EXT  = 3'd1,
      F_OPND = 3'd2,
      F_IMM  = 3'd3,
      HOLD   = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              mem_req_q, mem_req_d;
   logic              valid_q, valid_d;
   logic [1:0]        type_q, type_d;
   logic [7:0]        opcode_q, opcode_d;
   logic [7:0]        ext_q, ext_d;
   logic [7:0]        operand_q, operand_d;
   logic [7:0]        imm_q, imm_d;
   logic [2:0]        len_q, len_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   logic [3:0]        op_lo_c;
   logic [3:0]        op_idx_c;
   logic [1:0]        op_type_c;
   logic              take_c;

   // Opcode classifier on the raw memory byte
   always_comb begin
      op_lo_c  = bus.mem_rdata[3:0];
      op_idx_c = bus.mem_rdata[5:2];
      if (op_lo_c <= 4'd8) begin
         op_type_c = T_NORMAL;
      end else if (op_lo_c <= 4'hB) begin
         op_type_c = T_NORMAL_IMM;
      end else begin
         case (op_idx_c)
            4'h2, 4'h3, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: op_type_c = T_EXT_IMM;
            default:                                        op_type_c = T_EXT;
         endcase
      end
   end

   // Next state, byte capture and redirect handling
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      type_d     = type_q;
      opcode_d   = opcode_q;
      ext_d      = ext_q;
      operand_d  = operand_q;
      imm_d      = imm_q;
      len_d      = len_q;
      pc_d       = pc_q;
      take_c     = mem_req_q && bus.mem_ack;

      if (bus.redirect_valid) begin
         // Same-cycle ack and any partial bytes are abandoned
         state_d    = F_OP;
         fetch_pc_d = bus.redirect_pc;
      end else begin
         unique case (state_q)
            F_OP: begin
               if (take_c) begin
                  type_d    = op_type_c;
                  opcode_d  = bus.mem_rdata;
                  ext_d     = 8'h00;
                  operand_d = 8'h00;
                  imm_d     = 8'h00;
                  len_d     = 3'd2 + 3'(op_type_c[0]) + 3'(op_type_c[1]);
                  pc_d      = fetch_pc_q;
                  state_d   = op_type_c[1] ? F_EXT : F_OPND;
               end
            end
            F_EXT: begin
               if (take_c) begin
                  ext_d   = bus.mem_rdata;
                  state_d = F_OPND;
               end
            end
            F_OPND: begin
               if (take_c) begin
                  operand_d = bus.mem_rdata;
                  state_d   = type_q[0] ? F_IMM : HOLD;
               end
            end
            F_IMM: begin
               if (take_c) begin
                  imm_d   = bus.mem_rdata;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (valid_q && bus.instr_ready) begin
                  state_d = F_OP;
               end
            end
            default: state_d = F_OP;
         endcase

         if (take_c) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         end
      end

      // No prefetch: memory is idle exactly while an instruction is held
      valid_d   = (state_d == HOLD);
      mem_req_d = (state_d != HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= F_OP;
         fetch_pc_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         valid_q    <= 1'b0;
         type_q     <= 2'd0;
         opcode_q   <= 8'h00;
         ext_q      <= 8'h00;
         operand_q  <= 8'h00;
         imm_q      <= 8'h00;
         len_q      <= 3'd0;
         pc_q       <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_req_q  <= mem_req_d;
         valid_q    <= valid_d;
         type_q     <= type_d;
         opcode_q   <= opcode_d;
         ext_q      <= ext_d;
         operand_q  <= operand_d;
         imm_q      <= imm_d;
         len_q      <= len_d;
         pc_q       <= pc_d;
      end
   end

   assign bus.mem_req       = mem_req_q;
   assign bus.mem_addr      = fetch_pc_q;
   assign bus.instr_valid   = valid_q;
   assign bus.instr_type    = type_q;
   assign bus.instr_opcode  = opcode_q;
   assign bus.instr_ext     = ext_q;
   assign bus.instr_operand = operand_q;
   assign bus.instr_imm     = imm_q;
   assign bus.instr_len     = len_q;
   assign bus.instr_pc      = pc_q;

endmodule
